cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller at the memory-stage end of the pipeline. Consumes the M-stage exception code, delay-slot flag and PC carried by the EX/MEM register, and merges them with the hardware interrupt lines. It raises `Req`, which flushes every pipeline register to the handler (`0x4180`), and it maintains SR, Cause and EPC for `mfc0`, `mtc0` and `eret`.

## Interface
Parameters:
- `HANDLER_PC`, `32'h0000_4180`: exception entry address, exported for PC/flush logic.
- `PRID`, `32'h0000_0000`: value returned for register 15.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  `mtc0` write enable (M stage).
- `addr`  in  5  CP0 register number for read and write.
- `din`  in  32  `mtc0` write data.
- `dout`  out  32  `mfc0` read data, combinational.
- `M_PC`  in  32  PC of the M-stage instruction, or of the bubble holding its slot.
- `M_EXC`  in  5  M-stage ExcCode; 0 means none.
- `M_BD`  in  1  M-stage instruction is in a branch delay slot.
- `eret`  in  1  `eret` is in M stage.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `Req`  out  1  take exception/interrupt now, combinational.
- `EPC_out`  out  32  `eret` return target.

## Operation
- SR (reg 12):
  - `IM`=[15:10], `EXL`=[1], `IE`=[0]; all other bits read 0.
  - Writable by `mtc0`.
- Cause (reg 13):
  - `BD`=[31], `IP`=[15:10], `ExcCode`=[6:2]; all other bits read 0.
  - Read-only to software.
- EPC (reg 14): 32-bit, writable by `mtc0`.
- PRId (reg 15): constant `PRID`. Any other `addr` reads 0.
- Request logic:
  - `IntReq` = |(`HWInt` & `IM`) & `IE` & !`EXL`.
  - `ExcReq` = (`M_EXC` != 0) & !`EXL`.
  - `Req` = (`IntReq` | `ExcReq`) & !`rst`.
- On `Req`:
  - `EXL`<=1.
  - `BD`<=`M_BD`.
  - `ExcCode`<= 0 if `IntReq`, else `M_EXC`; interrupt has priority.
  - `EPC`<= `M_BD` ? `M_PC`-4 : `M_PC`, then forced to `{[31:2],2'b00}`.
- `IP`<=`HWInt` every cycle, regardless of `Req`/`EXL`.
- `mtc0` (`en`) takes effect only when !`Req`. `Req` wins over a simultaneous write.
- `eret` clears `EXL` only when !`Req`.
- `EPC_out`:
  - equals `din` when `en` & `addr`==14 & !`Req`, so a back-to-back `mtc0 EPC`/`eret` works;
  - otherwise equals `EPC`.
- A write to reg 13, 15 or an unlisted register is ignored.

## Timing
- Reset: on the `rst` edge, SR, Cause and EPC all become 0.
  - After reset: `dout`=0 for addr 12/13/14; `Req`=0; `EPC_out`=0.
  - `Req` is held 0 during the reset cycle.
- `Req`: same-cycle, 0 latency from `M_EXC`/`HWInt`/SR.
  - Pipeline registers sample it at the same edge on which CP0 updates.
- State updates occur on the next posedge. `dout` reflects the new value from that point.
- While `EXL`=1, neither exceptions nor interrupts are accepted.
  - A pending `M_EXC` is dropped.
  - An interrupt stays pending in `IP` and fires once `EXL` clears.
- An interrupt taken on a bubble uses the bubble's `M_PC`. The upstream stage must give bubbles the PC of the next real instruction.
- `mtc0 SR` that enables a pending interrupt: `Req` rises on the cycle after the write.

## Structure
- Shared `cp0_pkg`:
  - register numbers 12/13/14/15;
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12;
  - `HANDLER_PC`;
  - SR/Cause bit-position constants.
- Single module. No sub-module is needed; request/priority logic and the register file fit in one block.

## Test plan
- Reset:
  - Hold `rst` for 2 cycles with `M_EXC`=12.
  - Required: `Req`=0; `dout`=0 for addr 12, 13, 14.
- Interrupt:
  - `mtc0` SR=`0x0000_0401`, then `HWInt`=`6'b000001`, `M_PC`=`0x3008`.
  - Required: `Req`=1 in that cycle.
  - Next cycle: SR=`0x0000_0403`, Cause=`0x0000_0400`, EPC=`0x3008`.
- Delay-slot exception:
  - `M_EXC`=12, `M_BD`=1, `M_PC`=`0x3010`, `HWInt`=0, `EXL`=0.
  - Required: `Req`=1; Cause=`0x8000_0030`; EPC=`0x300C`.
- Masking:
  - With `EXL`=1, apply `M_EXC`=4 and `HWInt`=`6'b000001`.
  - Required: `Req`=0; EPC unchanged; Cause.IP=1.
  - Then `eret`. Required: `EXL`=0 next cycle, and `Req`=1 on the following cycle when `IE`=1 and `IM[10]`=1.
- Collisions:
  - Case A: interrupt and `M_EXC`=10 in the same cycle. Required: `ExcCode`=0.
  - Case B: `mtc0` EPC=`0x5000` with `Req`=1. Required: EPC=`M_PC`, not `0x5000`.
- Forwarding:
  - `mtc0` EPC=`0x3100` with `eret` in the same cycle.
  - Required: `EPC_out`=`0x3100` combinationally in that cycle.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, field positions, packing helpers.
// Used by the exception controller and by any decode logic that names CP0 registers.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IE_BIT     = 0;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] v;
    v = '0;
    v[SR_IM_MSB:SR_IM_LSB] = im;
    v[SR_EXL_BIT]          = exl;
    v[SR_IE_BIT]           = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] v;
    v = '0;
    v[CAUSE_BD_BIT]                = bd;
    v[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
    v[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: combinational Req, SR/Cause/EPC state.
// Req and dout are zero-latency; state updates on the next clk edge; no backpressure.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter logic [31:0] PRID       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic [31:0] M_PC,
  input  logic [4:0]  M_EXC,
  input  logic        M_BD,
  input  logic        eret,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] EPC_out
);

  // The handler address feeds the PC mux; it must be a word address.
  if (HANDLER_PC[1:0] != 2'b00) begin : g_bad_handler
    $error("HANDLER_PC must be word aligned");
  end

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_epc_raw;
  logic [31:0] w_epc_take;

  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (M_EXC != 5'd0) & ~r_exl;
  assign w_req     = (w_int_req | w_exc_req) & ~rst;
  assign Req       = w_req;

  // Software writes lose to a request arriving in the same cycle.
  assign w_wr_sr  = en & (addr == CP0_REG_SR)  & ~w_req;
  assign w_wr_epc = en & (addr == CP0_REG_EPC) & ~w_req;

  // A delay-slot fault restarts at the branch so the branch is re-executed.
  assign w_epc_raw  = M_BD ? (M_PC - 32'd4) : M_PC;
  assign w_epc_take = w_epc_raw & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_bd      <= M_BD;
        r_exccode <= w_int_req ? EXC_INT : M_EXC;
        r_epc     <= w_epc_take;
      end else begin
        if (w_wr_sr) begin
          r_im  <= din[SR_IM_MSB:SR_IM_LSB];
          r_exl <= din[SR_EXL_BIT];
          r_ie  <= din[SR_IE_BIT];
        end
        if (w_wr_epc) begin
          r_epc <= din;
        end
        // eret is ordered after the SR write so it always leaves EXL clear.
        if (eret) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      CP0_REG_SR:    dout = pack_sr(r_im, r_exl, r_ie);
      CP0_REG_CAUSE: dout = pack_cause(r_bd, r_ip, r_exccode);
      CP0_REG_EPC:   dout = r_epc;
      CP0_REG_PRID:  dout = PRID;
      default:       dout = '0;
    endcase
  end

  // Forward a same-cycle mtc0 EPC so mtc0/eret back to back returns to the new target.
  assign EPC_out = w_wr_epc ? din : r_epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scenario-driven bench for cp0_exc_ctrl with an expected-value queue.
module tb_cp0_exc_ctrl;

  typedef enum int { K_REQ, K_EPCO, K_REG } kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [4:0]  raddr;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] M_PC;
  logic [4:0]  M_EXC;
  logic        M_BD;
  logic        eret;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPC_out;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .addr(addr), .din(din), .dout(dout),
    .M_PC(M_PC), .M_EXC(M_EXC), .M_BD(M_BD), .eret(eret), .HWInt(HWInt),
    .Req(Req), .EPC_out(EPC_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; addr = 5'd0; din = '0; M_EXC = '0; M_BD = 1'b0; eret = 1'b0; HWInt = '0;
  endtask

  task automatic push(input string n, input kind_e k, input logic [4:0] a, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.raddr = a; e.val = v;
    exp_q.push_back(e);
  endtask

  // Observes the DUT for one expected entry; only register reads move addr.
  task automatic sample(input exp_t e, output logic [31:0] got);
    case (e.kind)
      K_REQ:   begin #1; got = {31'd0, Req}; end
      K_EPCO:  begin #1; got = EPC_out; end
      default: begin addr = e.raddr; #1; got = dout; end
    endcase
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    rst = 1'b1; idle(); M_PC = 32'h0; M_EXC = 5'd12;
    for (int c = 0; c < 2; c++) begin
      tick();
      push("reset_req_held", K_REQ, 5'd0, 32'd0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); sample(e, got); checks++;
        if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
      end
    end
    rst = 1'b0; idle();
    push("reset_req", K_REQ, 5'd0, 32'd0);
    push("reset_epc_out", K_EPCO, 5'd0, 32'd0);
    push("reset_sr", K_REG, 5'd12, 32'd0);
    push("reset_cause", K_REG, 5'd13, 32'd0);
    push("reset_epc", K_REG, 5'd14, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_interrupt();
    exp_t e; logic [31:0] got;
    idle(); en = 1'b1; addr = 5'd12; din = 32'h0000_0401;
    tick(); idle();
    HWInt = 6'b000001; M_PC = 32'h3008;
    push("int_req", K_REQ, 5'd0, 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); idle();
    push("int_sr", K_REG, 5'd12, 32'h0000_0403);
    push("int_cause", K_REG, 5'd13, 32'h0000_0400);
    push("int_epc", K_REG, 5'd14, 32'h0000_3008);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_delay_slot();
    exp_t e; logic [31:0] got;
    idle(); eret = 1'b1;
    tick(); idle();
    M_EXC = 5'd12; M_BD = 1'b1; M_PC = 32'h3010;
    push("ds_req", K_REQ, 5'd0, 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); idle();
    push("ds_cause", K_REG, 5'd13, 32'h8000_0030);
    push("ds_epc", K_REG, 5'd14, 32'h0000_300C);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_masking();
    exp_t e; logic [31:0] got;
    idle(); M_EXC = 5'd4; HWInt = 6'b000001; M_PC = 32'h3050;
    push("mask_req", K_REQ, 5'd0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); idle();
    push("mask_epc", K_REG, 5'd14, 32'h0000_300C);
    push("mask_cause_ip", K_REG, 5'd13, 32'h8000_0430);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    eret = 1'b1; HWInt = 6'b000001; M_PC = 32'h3020;
    push("mask_eret_req", K_REQ, 5'd0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); eret = 1'b0;
    push("mask_sr_exl_clear", K_REG, 5'd12, 32'h0000_0401);
    push("mask_pending_fires", K_REQ, 5'd0, 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    idle();
  endtask

  task automatic test_collision();
    exp_t e; logic [31:0] got;
    idle(); HWInt = 6'b000001; M_EXC = 5'd10; M_PC = 32'h3030;
    push("colA_req", K_REQ, 5'd0, 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); idle();
    push("colA_cause", K_REG, 5'd13, 32'h0000_0400);
    push("colA_epc", K_REG, 5'd14, 32'h0000_3030);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    eret = 1'b1;
    tick(); idle();
    en = 1'b1; addr = 5'd14; din = 32'h5000; M_EXC = 5'd12; M_PC = 32'h3040;
    push("colB_req", K_REQ, 5'd0, 32'd1);
    push("colB_epc_out", K_EPCO, 5'd0, 32'h0000_3030);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); idle();
    push("colB_epc", K_REG, 5'd14, 32'h0000_3040);
    push("colB_cause", K_REG, 5'd13, 32'h0000_0030);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] got;
    idle(); en = 1'b1; addr = 5'd14; din = 32'h3100; eret = 1'b1;
    push("fwd_req", K_REQ, 5'd0, 32'd0);
    push("fwd_epc_out", K_EPCO, 5'd0, 32'h0000_3100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); idle();
    push("fwd_epc", K_REG, 5'd14, 32'h0000_3100);
    push("fwd_sr", K_REG, 5'd12, 32'h0000_0401);
    push("fwd_epc_out_reg", K_EPCO, 5'd0, 32'h0000_3100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
  endtask

  task automatic test_sr_enable();
    exp_t e; logic [31:0] got;
    idle(); HWInt = 6'b000010;
    push("sren_masked_req", K_REQ, 5'd0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    en = 1'b1; addr = 5'd12; din = 32'h0000_0801;
    push("sren_write_cycle_req", K_REQ, 5'd0, 32'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    tick(); en = 1'b0; din = '0;
    push("sren_next_req", K_REQ, 5'd0, 32'd1);
    push("sren_sr", K_REG, 5'd12, 32'h0000_0801);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
    idle();
  endtask

  task automatic test_ignored_writes();
    exp_t e; logic [31:0] got;
    logic [4:0] waddr [3];
    waddr[0] = 5'd13; waddr[1] = 5'd15; waddr[2] = 5'd5;
    for (int i = 0; i < 3; i++) begin
      idle(); en = 1'b1; addr = waddr[i]; din = 32'hFFFF_FFFF;
      tick();
    end
    idle();
    push("ign_cause", K_REG, 5'd13, 32'h0000_0030);
    push("ign_prid", K_REG, 5'd15, 32'h0000_0000);
    push("ign_unlisted", K_REG, 5'd5, 32'h0000_0000);
    push("ign_sr", K_REG, 5'd12, 32'h0000_0801);
    push("ign_epc", K_REG, 5'd14, 32'h0000_3100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); sample(e, got); checks++;
      if (got !== e.val) begin errors++; $display("FAIL %s got %h exp %h", e.name, got, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_delay_slot();
    test_masking();
    test_collision();
    test_back_to_back();
    test_sr_enable();
    test_ignored_writes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
